// File: rtl/uv_apb_mst.sv
// uv_apb_mst: single-outstanding valid/ready request/response port to APB4
// initiator, with an optional pready timeout that turns a hung slave into an
// error response.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; APB bus idle
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1; waiting for pready or the timeout
// RESP   | rsp_vld=1; holding the response until rsp_rdy
module uv_apb_mst #(
    parameter int ALEN       = 32,
    parameter int DLEN       = 32,
    parameter int MLEN       = DLEN / 8,
    parameter int TMO_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic            req_read,
    input  logic [ALEN-1:0] req_addr,
    input  logic [MLEN-1:0] req_mask,
    input  logic [DLEN-1:0] req_data,
    input  logic [2:0]      req_prot,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic            rsp_excp,
    output logic [DLEN-1:0] rsp_data,
    output logic            apb_psel,
    output logic            apb_penable,
    output logic [2:0]      apb_pprot,
    output logic [ALEN-1:0] apb_paddr,
    output logic [MLEN-1:0] apb_pstrb,
    output logic            apb_pwrite,
    output logic [DLEN-1:0] apb_pwdata,
    input  logic [DLEN-1:0] apb_prdata,
    input  logic            apb_pready,
    input  logic            apb_pslverr
);

    // Counter only needs to reach TMO_CYCLES-1; it saturates above that
    // (only relevant when the timeout is disabled).
    localparam int CW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (TMO_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    assign req_rdy = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; pready takes priority over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (apb_pready || tmo_hit) state_nxt = RESP;
            RESP:    if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // APB outputs: request fields captured on accept and held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pstrb   <= '0;
            apb_pwdata  <= '0;
            apb_pprot   <= '0;
        end else begin
            if (state == IDLE && req_vld) begin
                apb_psel   <= 1'b1;
                apb_pwrite <= !req_read;
                apb_paddr  <= req_addr;
                apb_pstrb  <= req_read ? '0 : req_mask;
                apb_pwdata <= req_read ? '0 : req_data;
                apb_pprot  <= req_prot;
            end
            if (state == SETUP) begin
                apb_penable <= 1'b1;
            end
            if (state == ACCESS && state_nxt == RESP) begin
                apb_psel    <= 1'b0;
                apb_penable <= 1'b0;
            end
        end
    end

    // Timeout counter: counts ACCESS cycles without pready, cleared on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && state_nxt != ACCESS) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && tmo_cnt != {CW{1'b1}}) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Response registers: loaded when ACCESS ends, rsp_data kept after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld  <= 1'b0;
            rsp_excp <= 1'b0;
            rsp_data <= '0;
        end else if (state == ACCESS && apb_pready) begin
            rsp_vld  <= 1'b1;
            rsp_excp <= apb_pslverr;
            rsp_data <= (!apb_pwrite && !apb_pslverr) ? apb_prdata : '0;
        end else if (state == ACCESS && tmo_hit) begin
            rsp_vld  <= 1'b1;
            rsp_excp <= 1'b1;
            rsp_data <= '0;
        end else if (state == RESP && rsp_rdy) begin
            rsp_vld  <= 1'b0;
            rsp_excp <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uv_apb_mst.sv
// Bench for uv_apb_mst. The model describes each transfer as a timeline:
// accept interval A, number of ACCESS cycles n, handshake interval H.
// All bus/response expectations per cycle are derived from those numbers.
`timescale 1ns/1ps
module tb_uv_apb_mst;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_read = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic        rsp_excp;
    logic [31:0] rsp_data;
    logic        apb_psel;
    logic        apb_penable;
    logic [2:0]  apb_pprot;
    logic [31:0] apb_paddr;
    logic [3:0]  apb_pstrb;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata = '0;
    logic        apb_pready = 1'b0;
    logic        apb_pslverr = 1'b0;

    uv_apb_mst #(.ALEN(32), .DLEN(32), .MLEN(4), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_read(req_read),
        .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
        .req_prot(req_prot),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_excp(rsp_excp),
        .rsp_data(rsp_data),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pprot(apb_pprot),
        .apb_paddr(apb_paddr), .apb_pstrb(apb_pstrb), .apb_pwrite(apb_pwrite),
        .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // transfer model
    bit          chk_en = 1'b0;
    bit          m_act = 1'b0;
    int          m_a = 0;
    int          m_n = 0;
    int          m_h = 0;
    bit          m_rd;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    bit          m_excp;
    logic [31:0] m_rdata;

    // per-transfer observations used by the literal checks
    int          psel_cnt = 0;
    int          pen_cnt = 0;
    int          rv_first = 0;
    bit          rv_seen = 1'b0;
    logic [31:0] cap_data = '0;
    logic        cap_excp = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (apb_psel) psel_cnt++;
            if (apb_penable) pen_cnt++;
            if (rsp_vld && !rv_seen) begin
                rv_seen = 1'b1;
                rv_first = cyc;
            end
            if (rsp_vld && rsp_rdy) begin
                cap_data = rsp_data;
                cap_excp = rsp_excp;
            end
        end
    end

    // per-cycle compare against the timeline model
    always @(negedge clk) begin
        bit e_busy, e_psel, e_pen, e_rv;
        if (chk_en) begin
            e_busy = m_act && cyc > m_a && cyc <= m_h;
            e_psel = m_act && cyc >= m_a + 1 && cyc <= m_a + 1 + m_n;
            e_pen  = m_act && cyc >= m_a + 2 && cyc <= m_a + 1 + m_n;
            e_rv   = m_act && cyc >= m_a + 2 + m_n && cyc <= m_h;
            chk("req_rdy", req_rdy, !e_busy);
            chk("psel", apb_psel, e_psel);
            chk("penable", apb_penable, e_pen);
            chk("rsp_vld", rsp_vld, e_rv);
            if (e_psel) begin
                chk("paddr", apb_paddr, m_addr);
                chk("pwrite", apb_pwrite, !m_rd);
                chk("pstrb", apb_pstrb, m_strb);
                chk("pwdata", apb_pwdata, m_wdata);
                chk("pprot", apb_pprot, m_prot);
            end
            if (e_rv) begin
                chk("rsp_excp", rsp_excp, m_excp);
                chk("rsp_data", rsp_data, m_rdata);
            end
        end
    end

    // Drives one transfer with w slave wait states and rwait cycles of response
    // backpressure. Called at posedge+1 of an interval where the DUT is idle.
    task automatic xfer(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] mask, input logic [2:0] prot, input int w,
                        input bit err, input logic [31:0] rdat, input int rwait,
                        input bit early);
        bit tmo;
        tmo     = (TMO != 0) && (w >= TMO);
        m_n     = tmo ? TMO : w + 1;
        m_a     = cyc;
        m_h     = m_a + 2 + m_n + rwait;
        m_rd    = rd;
        m_addr  = addr;
        m_strb  = rd ? 4'h0 : mask;
        m_wdata = rd ? 32'h0 : wd;
        m_prot  = prot;
        m_excp  = tmo || err;
        m_rdata = (rd && !m_excp) ? rdat : 32'h0;
        m_act   = 1'b1;
        psel_cnt = 0;
        pen_cnt = 0;
        rv_seen = 1'b0;
        req_vld = 1'b1;
        req_read = rd;
        req_addr = addr;
        req_data = wd;
        req_mask = mask;
        req_prot = prot;
        rsp_rdy = (rwait == 0);
        @(posedge clk); #1;
        // a pending request with different fields must not disturb this transfer
        req_vld = early;
        req_addr = ~addr;
        req_data = ~wd;
        while (cyc <= m_h) begin
            apb_pready  = (cyc == m_a + 2 + w) && (cyc <= m_a + 1 + m_n);
            apb_pslverr = apb_pready && err;
            apb_prdata  = apb_pready ? rdat : 32'hDEAD_BEEF;
            rsp_rdy     = (rwait == 0) || (cyc == m_h);
            @(posedge clk); #1;
        end
        apb_pready = 1'b0;
        apb_pslverr = 1'b0;
        rsp_rdy = 1'b0;
        req_vld = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", apb_psel, 0);
        chk("rst_penable", apb_penable, 0);
        chk("rst_pwrite", apb_pwrite, 0);
        chk("rst_paddr", apb_paddr, 0);
        chk("rst_pstrb", apb_pstrb, 0);
        chk("rst_pwdata", apb_pwdata, 0);
        chk("rst_pprot", apb_pprot, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_excp", rsp_excp, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_rdy", req_rdy, 1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // zero-wait write
        xfer(1'b0, 32'h008, 32'h0000_0064, 4'hF, 3'b000, 0, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
        chk("wr_latency", rv_first - m_a, 3);
        chk("wr_psel_cycles", psel_cnt, 2);
        chk("wr_pen_cycles", pen_cnt, 1);
        chk("wr_rsp_data", cap_data, 32'h0);
        chk("wr_rsp_excp", cap_excp, 1'b0);

        // read with 3 wait states, back to back
        xfer(1'b1, 32'h004, 32'h0, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
        chk("rd_pen_cycles", pen_cnt, 4);
        chk("rd_rsp_data", cap_data, 32'h1234_5678);
        chk("rd_rsp_excp", cap_excp, 1'b0);

        // slave error
        xfer(1'b1, 32'h010, 32'h0, 4'h0, 3'b001, 0, 1'b1, 32'h5555_AAAA, 0, 1'b0);
        chk("err_rsp_excp", cap_excp, 1'b1);
        chk("err_rsp_data", cap_data, 32'h0);

        // timeout with pready never arriving
        xfer(1'b1, 32'h020, 32'h0, 4'h0, 3'b000, 100, 1'b0, 32'h1111_2222, 0, 1'b0);
        chk("tmo_pen_cycles", pen_cnt, 4);
        chk("tmo_rsp_excp", cap_excp, 1'b1);
        chk("tmo_rsp_data", cap_data, 32'h0);

        // pready in the last possible ACCESS cycle wins over the timeout
        xfer(1'b1, 32'h024, 32'h0, 4'h0, 3'b000, 3, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
        chk("late_pen_cycles", pen_cnt, 4);
        chk("late_rsp_excp", cap_excp, 1'b0);
        chk("late_rsp_data", cap_data, 32'h0BAD_F00D);

        // second timeout: counter must have restarted from zero
        xfer(1'b0, 32'h028, 32'h0000_00FF, 4'h1, 3'b111, 50, 1'b0, 32'h0, 0, 1'b0);
        chk("tmo2_pen_cycles", pen_cnt, 4);
        chk("tmo2_rsp_excp", cap_excp, 1'b1);

        // response backpressure with a pending request, then immediate next request
        xfer(1'b1, 32'h030, 32'h0, 4'hF, 3'b101, 1, 1'b0, 32'hA5A5_5A5A, 5, 1'b1);
        chk("bp_rsp_data", cap_data, 32'hA5A5_5A5A);
        xfer(1'b1, 32'h034, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h0000_0077, 0, 1'b0);
        chk("b2b_latency", rv_first - m_a, 3);
        chk("b2b_rsp_data", cap_data, 32'h0000_0077);

        // reset asserted during ACCESS
        chk_en = 1'b0;
        req_vld = 1'b1;
        req_read = 1'b1;
        req_addr = 32'h040;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(posedge clk); #1;
        chk("mid_psel", apb_psel, 1);
        chk("mid_penable", apb_penable, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_psel", apb_psel, 0);
        chk("arst_penable", apb_penable, 0);
        chk("arst_rsp_vld", rsp_vld, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_act = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_rdy", req_rdy, 1);
        xfer(1'b1, 32'h044, 32'h0, 4'hF, 3'b000, 2, 1'b0, 32'h1357_9BDF, 0, 1'b0);
        chk("post_rst_rsp_data", cap_data, 32'h1357_9BDF);
        chk("post_rst_rsp_excp", cap_excp, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
